// File: rtl/random_phase_sequencer.sv
// random_phase_sequencer: alternating low/high phases with LFSR-drawn lengths from programmable windows.
// Define RPS_SEED_PORT_EN to add a seed_i port that reseeds the LFSR on every accepted start.
module random_phase_sequencer #(
  parameter int          CNT_W     = 8,
  parameter int          PER_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk_i,
  input  logic             s_rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] lo_min_i,
  input  logic [CNT_W-1:0] lo_max_i,
  input  logic [CNT_W-1:0] hi_min_i,
  input  logic [CNT_W-1:0] hi_max_i,
  input  logic [PER_W-1:0] hi_periods_i,
`ifdef RPS_SEED_PORT_EN
  input  logic [15:0]      seed_i,
`endif
  output logic             state_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             cfg_err_o,
  output logic [PER_W-1:0] period_cnt_o
);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] lfsr_q, seed_eff, src;
  logic [CNT_W-1:0] cnt_q, lo_min_q, lo_max_q, hi_min_q, hi_max_q, mn, mx, len;
  logic [PER_W-1:0] hi_per_q, pc_inc;
  logic [CNT_W:0] span;
  logic [2*CNT_W-1:0] prod;
  logic cfg_ok, req, accept, phase_end, fin, cfg_err_q;
`ifdef RPS_SEED_PORT_EN
  assign seed_eff = seed_i == 16'h0 ? LFSR_SEED : seed_i;
`else
  assign seed_eff = LFSR_SEED;
`endif
  // The start-cycle draw uses the freshly loaded seed and the live window ports.
  always_comb begin
    cfg_ok    = lo_min_i != '0 && lo_min_i <= lo_max_i && hi_min_i != '0 && hi_min_i <= hi_max_i;
    req       = state_q == IDLE && start_i && !stop_i;
    accept    = req && cfg_ok;
    phase_end = (state_q == LO || state_q == HI) && cnt_q == '0 && !stop_i;
    pc_inc    = period_cnt_o + PER_W'(1);
    fin       = hi_per_q != '0 && pc_inc == hi_per_q;
    src       = accept ? seed_eff : lfsr_q;
    mn        = accept ? lo_min_i : state_q == LO ? hi_min_q : lo_min_q;
    mx        = accept ? lo_max_i : state_q == LO ? hi_max_q : lo_max_q;
    span      = {1'b0, mx} - {1'b0, mn} + (CNT_W+1)'(1);
    prod      = (2*CNT_W)'(src[CNT_W-1:0]) * (2*CNT_W)'(span);
    len       = mn + CNT_W'(prod >> CNT_W);
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? LO : IDLE;
      LO:      state_d = stop_i ? IDLE : cnt_q != '0 ? LO : HI;
      HI:      state_d = stop_i ? IDLE : cnt_q != '0 ? HI : fin ? DONE : LO;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i)
    if (s_rst_i) state_q <= IDLE;
    else         state_q <= state_d;
  // Counter holds len-1 so a phase ends on the cycle it reads zero.
  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      lfsr_q       <= LFSR_SEED;
      cnt_q        <= '0;
      period_cnt_o <= '0;
      cfg_err_q    <= 1'b0;
      lo_min_q     <= '0;
      lo_max_q     <= '0;
      hi_min_q     <= '0;
      hi_max_q     <= '0;
      hi_per_q     <= '0;
    end else begin
      cfg_err_q <= req && !cfg_ok;
      if (accept) begin
        lo_min_q     <= lo_min_i;
        lo_max_q     <= lo_max_i;
        hi_min_q     <= hi_min_i;
        hi_max_q     <= hi_max_i;
        hi_per_q     <= hi_periods_i;
        period_cnt_o <= '0;
      end else if (phase_end && state_q == HI) period_cnt_o <= pc_inc;
      if (accept || phase_end) begin
        lfsr_q <= {src[14:0], src[15] ^ src[13] ^ src[12] ^ src[10]};
        cnt_q  <= len - CNT_W'(1);
      end else if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
    end
  end
  assign state_o   = state_q == HI;
  assign busy_o    = state_q == LO || state_q == HI;
  assign done_o    = state_q == DONE;
  assign cfg_err_o = cfg_err_q;
endmodule

// File: tb/tb_random_phase_sequencer.sv
// tb_random_phase_sequencer: randomized runs checked against a phase-list reference model.
module tb_random_phase_sequencer;
  logic clk_i = 1'b0, s_rst_i, start_i, stop_i;
  logic [7:0] lo_min_i, lo_max_i, hi_min_i, hi_max_i;
  logic [15:0] hi_periods_i, seed_i, period_cnt_o;
  logic state_o, busy_o, done_o, cfg_err_o;
  int n_cmp = 0, n_bad = 0;
  bit rec[$], sav[$];
  random_phase_sequencer dut (
    .clk_i(clk_i), .s_rst_i(s_rst_i), .start_i(start_i), .stop_i(stop_i),
    .lo_min_i(lo_min_i), .lo_max_i(lo_max_i), .hi_min_i(hi_min_i), .hi_max_i(hi_max_i),
    .hi_periods_i(hi_periods_i),
`ifdef RPS_SEED_PORT_EN
    .seed_i(seed_i),
`endif
    .state_o(state_o), .busy_o(busy_o), .done_o(done_o), .cfg_err_o(cfg_err_o),
    .period_cnt_o(period_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic do_reset;
    s_rst_i = 1'b1;
    tick();
    s_rst_i = 1'b0;
  endtask
  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction
  function automatic int draw(input int mn, input int mx, input logic [15:0] l);
    return mn + (int'(l[7:0]) * (mx - mn + 1)) / 256;
  endfunction
  task automatic set_cfg(input int lmn, input int lmx, input int hmn, input int hmx, input int hp);
    lo_min_i = 8'(lmn); lo_max_i = 8'(lmx); hi_min_i = 8'(hmn); hi_max_i = 8'(hmx);
    hi_periods_i = 16'(hp);
  endtask
  // Reference: list of phases built from the window rules, expanded to one entry per cycle.
  task automatic run(input int lmn, input int lmx, input int hmn, input int hmx, input int hp,
                     input logic [15:0] sd, input bit poke);
    bit q[$];
    int pq[$];
    logic [15:0] l = sd == 16'h0 ? 16'hACE1 : sd;
    int pc = 0, len;
    do begin
      len = draw(lmn, lmx, l); l = lfsr_step(l);
      repeat (len) begin q.push_back(1'b0); pq.push_back(pc); end
      len = draw(hmn, hmx, l); l = lfsr_step(l);
      repeat (len) begin q.push_back(1'b1); pq.push_back(pc); end
      pc++;
    end while (pc != hp);
    set_cfg(lmn, lmx, hmn, hmx, hp);
    seed_i = sd;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    rec.delete();
    foreach (q[i]) begin
      chk("state", state_o, q[i]);
      chk("busy", busy_o, 1);
      chk("pcnt", period_cnt_o, pq[i]);
      rec.push_back(state_o);
      if (poke) begin
        start_i = 1'($urandom);
        set_cfg($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 9));
        seed_i = 16'($urandom);
      end
      tick();
    end
    start_i = 1'b0;
    chk("done", done_o, 1);
    chk("done_busy", busy_o, 0);
    chk("done_state", state_o, 0);
    chk("done_pcnt", period_cnt_o, hp);
    tick();
    chk("done_clr", done_o, 0);
    chk("idle_pcnt", period_cnt_o, hp);
  endtask
  function automatic int diffs();
    int d = (rec.size() != sav.size()) ? 1 : 0;
    foreach (rec[i]) if (i < sav.size() && rec[i] != sav[i]) d++;
    return d;
  endfunction
  initial begin
    int cur, hi_runs, bad;
    s_rst_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; seed_i = 16'h0;
    set_cfg(0, 0, 0, 0, 0);
    do_reset();
    chk("rst_state", state_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", cfg_err_o, 0);
    chk("rst_pcnt", period_cnt_o, 0);
    set_cfg(3, 3, 5, 5, 2);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      chk("fix_state", state_o, (k >= 4 && k <= 8) || k >= 12);
      chk("fix_busy", busy_o, 1);
      tick();
    end
    chk("fix_done", done_o, 1);
    chk("fix_pcnt", period_cnt_o, 2);
    chk("fix_busy_end", busy_o, 0);
    do_reset();
    run(10, 20, 30, 40, 50, 16'h0, 1'b0);
    cur = 0; hi_runs = 0; bad = 0;
    foreach (rec[i]) begin
      if (i > 0 && rec[i] != rec[i-1]) begin
        if (rec[i-1]) begin hi_runs++; if (cur < 30 || cur > 40) bad++; end
        else if (cur < 10 || cur > 20) bad++;
        cur = 0;
      end
      cur++;
    end
    if (rec.size() > 0 && rec[rec.size()-1]) begin hi_runs++; if (cur < 30 || cur > 40) bad++; end
    chk("runlen_bad", bad, 0);
    chk("hi_runs", hi_runs, 50);
    sav = rec;
    do_reset();
    run(10, 20, 30, 40, 50, 16'h0, 1'b0);
    chk("repeatable", diffs(), 0);
    run(1, 255, 200, 255, 3, 16'h0, 1'b0);
    for (int it = 0; it < 6; it++) begin
      int lmn = $urandom_range(1, 6), hmn = $urandom_range(1, 6);
      run(lmn, lmn + $urandom_range(0, 8), hmn, hmn + $urandom_range(0, 8), $urandom_range(1, 4),
          16'h0, 1'b1);
    end
    set_cfg(8, 4, 2, 3, 1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("bad_lo_err", cfg_err_o, 1);
    chk("bad_lo_busy", busy_o, 0);
    tick();
    chk("bad_lo_err_clr", cfg_err_o, 0);
    chk("bad_lo_busy2", busy_o, 0);
    set_cfg(2, 3, 0, 4, 1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("bad_hi_err", cfg_err_o, 1);
    chk("bad_hi_busy", busy_o, 0);
    tick();
    chk("bad_hi_err_clr", cfg_err_o, 0);
    set_cfg(4, 4, 4, 4, 0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (5) tick();
    chk("abort_pre", state_o, 1);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    chk("abort_state", state_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    chk("abort_pcnt", period_cnt_o, 0);
    tick();
    chk("abort_done2", done_o, 0);
    chk("abort_busy2", busy_o, 0);
    start_i = 1'b1; stop_i = 1'b1;
    tick();
    start_i = 1'b0; stop_i = 1'b0;
    chk("contend_busy", busy_o, 0);
    chk("contend_err", cfg_err_o, 0);
    tick();
    chk("contend_busy2", busy_o, 0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (5) tick();
    chk("rst_mid_pre", state_o, 1);
    s_rst_i = 1'b1;
    tick();
    s_rst_i = 1'b0;
    chk("rst_mid_state", state_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_done", done_o, 0);
    chk("rst_mid_pcnt", period_cnt_o, 0);
`ifdef RPS_SEED_PORT_EN
    run(3, 30, 3, 30, 4, 16'h1234, 1'b0);
    sav = rec;
    run(3, 30, 3, 30, 4, 16'h0, 1'b0);
    chk("seed_differs", diffs() != 0, 1);
    sav = rec;
    run(3, 30, 3, 30, 4, 16'hACE1, 1'b0);
    chk("seed0_default", diffs(), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/random_phase_sequencer.md
Name: random_phase_sequencer

Overview:
- Controller that sequences an alternating low/high output phase pattern with pseudo-random phase lengths.
- Each phase length is drawn from a programmable [min,max] window by a synthesizable 16-bit LFSR; no simulation-only random calls.
- Runs a programmed number of high phases (or free-runs) and reports completion.
- Sits in front of traffic/valid-throttling logic in testbenches and on-chip stress blocks as the synthesizable on/off stimulus source.

Parameters:
- CNT_W, 8, width of phase-length window ports and internal down-counter.
- PER_W, 16, width of the high-phase count port and of period_cnt_o.
- LFSR_SEED, 16'hACE1, LFSR value loaded at reset and at every accepted start; must be nonzero.

Ports:
- clk_i  in  1  clock.
- s_rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  start request, sampled only in IDLE.
- stop_i  in  1  abort request.
- lo_min_i  in  CNT_W  minimum low-phase length, cycles.
- lo_max_i  in  CNT_W  maximum low-phase length, cycles.
- hi_min_i  in  CNT_W  minimum high-phase length, cycles.
- hi_max_i  in  CNT_W  maximum high-phase length, cycles.
- hi_periods_i  in  PER_W  number of high phases to run; 0 = run until stop.
- state_o  out  1  generated phase level.
- busy_o  out  1  high from the cycle after an accepted start until return to IDLE.
- done_o  out  1  one-cycle pulse when the programmed count completes.
- cfg_err_o  out  1  one-cycle pulse when a start is rejected.
- period_cnt_o  out  PER_W  high phases completed in the current run.

Behaviour:
- Reset: FSM=IDLE, LFSR=LFSR_SEED, counter=0, all outputs 0, period_cnt_o=0.
- States: IDLE, LO, HI, DONE.
- state_o is 1 only in HI. busy_o is 1 in LO and HI.
- Config latch: on start_i in IDLE, all window ports and hi_periods_i are latched. They are ignored afterwards.
- Start rejection: if min=0 or min>max for either window, stay in IDLE, pulse cfg_err_o for 1 cycle, latch nothing.
- Valid start: LFSR reloads LFSR_SEED and period_cnt_o clears to 0. The next cycle is the first LO cycle (latency 1).
- Length draw, one cycle, combinational from the current LFSR value:
  - span = max-min+1, width CNT_W+1.
  - r = LFSR[CNT_W-1:0].
  - len = min + ((r*span) >> CNT_W), so len lies in [min,max].
  - The LFSR advances once per draw.
  - Draws occur on the start cycle (first LO length) and on the last cycle of every phase (next phase length).
- LFSR polynomial: x^16+x^14+x^13+x^11+1, Fibonacci, shift left, feedback into bit 0.
- Phase timing: a phase drawn as len holds state_o at a constant level for exactly len cycles. Phases abut with no gap cycle.
- LO end: go to HI.
- HI end:
  - period_cnt_o increments (wraps at 2^PER_W).
  - If hi_periods≠0 and the new count equals hi_periods, go to DONE.
  - Otherwise go to LO.
- DONE: lasts 1 cycle with done_o=1, state_o=0, busy_o=0, then IDLE. period_cnt_o holds its value until the next valid start.
- stop_i in LO or HI: next cycle IDLE, state_o=0, no done_o pulse, period_cnt_o holds.
- stop_i in DONE or IDLE: no effect.
- start_i and stop_i together in IDLE: stop wins, start is ignored.
- start_i while busy: ignored.
- s_rst_i mid-run: overrides everything; next cycle equals the reset state.
- hi_periods_i=0: free-runs; period_cnt_o wraps silently.

Optional Feature:
- Macro: RPS_SEED_PORT_EN.
- When defined:
  - Adds input seed_i [15:0].
  - A valid start loads seed_i instead of LFSR_SEED.
  - seed_i=0 is replaced by LFSR_SEED, so the LFSR never locks up.
  - Reset still loads LFSR_SEED.
- When undefined: no seed_i port; the LFSR always starts from LFSR_SEED.

Test Plan:
- Fixed lengths: lo=3..3, hi=5..5, hi_periods=2, start at cycle t.
  - state_o: 0 for t+1..t+3, 1 for t+4..t+8, 0 for t+9..t+11, 1 for t+12..t+16.
  - done_o=1 at t+17; period_cnt_o=2; busy_o=0 from t+17.
- Random window: lo=10..20, hi=30..40, hi_periods=50.
  - Every LO run length lies in [10,20] and every HI run length in [30,40].
  - Exactly 50 HI runs, then 1 done_o pulse.
  - Two runs from reset give identical sequences.
- Bad config: start with lo_min=8, lo_max=4 → cfg_err_o pulse at t+1, busy_o stays 0. Repeat with hi_min=0 → same result.
- Abort: hi_periods=0, lo=hi=4..4, stop_i on the 2nd HI cycle → next cycle IDLE, state_o=0, no done_o, period_cnt_o=0.
- Contention: start_i and stop_i together in IDLE → no run. start_i pulsed while busy → sequence unchanged. s_rst_i mid-HI → all outputs 0 next cycle.
- With RPS_SEED_PORT_EN: seed_i=16'h1234 vs 16'h0 → different length sequences. Seed 0 matches a run without the macro.
